// File: rtl/neur_seq_pkg.sv
// Shared state encoding and bias/shift/mode word layout for the neural-unit sequencer.
package neur_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BIAS   = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_FETCH  = 3'd4,
      ST_OUTPUT = 3'd5
   } neur_seq_state_e;

   localparam int BSM_MODE_LSB = 0;
   localparam int BSM_MODE_MSB = 2;
   localparam int BSM_SH_W     = 5;
   localparam int BSM_SH0_LSB  = 6;
   localparam int BSM_SH1_LSB  = 13;
   localparam int BSM_SH2_LSB  = 20;
   localparam int BSM_SH3_LSB  = 27;

   // Builds a bias/shift/mode word; unused bit positions stay zero.
   function automatic logic [31:0] bsm_pack(
      input logic [2:0] mode,
      input logic [4:0] sh0,
      input logic [4:0] sh1,
      input logic [4:0] sh2,
      input logic [4:0] sh3
   );
      logic [31:0] w;
      w = '0;
      w[BSM_MODE_MSB:BSM_MODE_LSB] = mode;
      w[BSM_SH0_LSB +: BSM_SH_W]   = sh0;
      w[BSM_SH1_LSB +: BSM_SH_W]   = sh1;
      w[BSM_SH2_LSB +: BSM_SH_W]   = sh2;
      w[BSM_SH3_LSB +: BSM_SH_W]   = sh3;
      return w;
   endfunction

endpackage

// File: rtl/neur_seq_ctrl.sv
// Job sequencer in front of the neural unit: bias load, pair streaming,
// pipeline drain, result fetch and a ready/valid result port.
module neur_seq_ctrl
   import neur_seq_pkg::*;
#(
   parameter int LEN_W     = 16,
   parameter int DRAIN_CYC = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      cfg_bias_i,
   input  logic [31:0]      cfg_bsm_i,
   input  logic [LEN_W-1:0] cfg_len_i,
   output logic             busy_o,
   output logic             done_o,
   input  logic             data_valid_i,
   output logic             data_ready_o,
   input  logic [31:0]      data_weight_i,
   input  logic [31:0]      data_input_i,
   output logic             nu_bias_in_o,
   output logic             nu_valid_in_o,
   output logic             nu_get_res_o,
   output logic [31:0]      nu_bias_shift_mode_o,
   output logic [31:0]      nu_weights_o,
   output logic [31:0]      nu_input_val_o,
   input  logic             nu_valid_out_i,
   input  logic [31:0]      nu_output_val_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [31:0]      res_data_o
);

   // One extra counter bit so the maximum length terminates without wrapping.
   localparam int CNT_W = LEN_W + 1;
   localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

   neur_seq_state_e  r_state;
   neur_seq_state_e  w_state_nxt;
   logic [31:0]      r_bias;
   logic [31:0]      r_bsm;
   logic [31:0]      r_result;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [DRN_W-1:0] r_drain;
   logic             w_pair_hs;
   logic             w_last_pair;

   assign w_pair_hs   = (r_state == ST_STREAM) && data_valid_i;
   assign w_cnt_inc   = r_cnt + CNT_W'(1);
   assign w_last_pair = (w_cnt_inc == r_len);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bias   <= '0;
         r_bsm    <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_drain  <= '0;
         r_result <= '0;
      end else begin
         if ((r_state == ST_IDLE) && start_i) begin
            r_bias <= cfg_bias_i;
            r_bsm  <= cfg_bsm_i;
            r_len  <= {1'b0, cfg_len_i};
            r_cnt  <= '0;
         end
         if (w_pair_hs) begin
            r_cnt <= w_cnt_inc;
         end
         if (r_state == ST_DRAIN) begin
            r_drain <= r_drain + DRN_W'(1);
         end else begin
            r_drain <= '0;
         end
         // Valid-out pulses seen outside FETCH belong to bias/data strobes.
         if ((r_state == ST_FETCH) && nu_valid_out_i) begin
            r_result <= nu_output_val_i;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start_i) w_state_nxt = ST_BIAS;
         end
         ST_BIAS: begin
            if (r_len == '0) w_state_nxt = ST_DRAIN;
            else             w_state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            if (w_pair_hs && w_last_pair) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (r_drain == DRN_LAST) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (nu_valid_out_i) w_state_nxt = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (res_ready_i) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake rule: a transfer happens in any cycle where valid and ready are both high.
   always_comb begin
      busy_o               = (r_state != ST_IDLE);
      done_o               = 1'b0;
      data_ready_o         = 1'b0;
      nu_bias_in_o         = 1'b0;
      nu_valid_in_o        = 1'b0;
      nu_get_res_o         = 1'b0;
      nu_bias_shift_mode_o = (r_state != ST_IDLE) ? r_bsm : 32'h0;
      nu_weights_o         = 32'h0;
      nu_input_val_o       = 32'h0;
      res_valid_o          = 1'b0;
      res_data_o           = 32'h0;
      case (r_state)
         ST_BIAS: begin
            nu_bias_in_o = 1'b1;
            nu_weights_o = r_bias;
         end
         ST_STREAM: begin
            data_ready_o  = 1'b1;
            nu_valid_in_o = data_valid_i;
            if (data_valid_i) begin
               nu_weights_o   = data_weight_i;
               nu_input_val_o = data_input_i;
            end
         end
         ST_FETCH: begin
            nu_get_res_o = 1'b1;
         end
         ST_OUTPUT: begin
            res_valid_o = 1'b1;
            res_data_o  = r_result;
            done_o      = res_ready_i;
         end
         default: ;
      endcase
   end

endmodule
